mac_arbiter: RTL

MAC_ARBITER -- requirements
Module: mac_arbiter

---
 rtl/mac_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/mac_arbiter.sv
// mac_arbiter: shares one mult_reduce among NUM_REQ requesters in NUM_ELEMENTS-pair bursts and tags each result with its requester.
// Define MAC_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise the lowest-index valid requester wins.
module mac_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 12,
  parameter int NUM_ELEMENTS = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_REQ-1:0] req_valid_in,
  output logic [NUM_REQ-1:0] req_ready_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dataa_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_datab_in,
  output logic mac_valid_out,
  input  logic mac_ready_out,
  output logic [DATA_WIDTH-1:0] mac_dataa_out,
  output logic [DATA_WIDTH-1:0] mac_datab_out,
  input  logic mac_valid_in,
  output logic mac_ready_in,
  input  logic [2*DATA_WIDTH-1:0] mac_result_in,
  output logic res_valid_out,
  input  logic res_ready_out,
  output logic [2*DATA_WIDTH-1:0] res_data_out,
  output logic [$clog2(NUM_REQ)-1:0] res_id_out
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(NUM_ELEMENTS+1);
  typedef enum logic [1:0] {IDLE, BURST, WAIT, OUTPUT} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] grant, pick;
  logic [CW-1:0] cnt;
  logic pair_hs, last_pair;
  assign pair_hs = mac_valid_out && mac_ready_out;
  assign last_pair = pair_hs && (cnt == CW'(NUM_ELEMENTS-1));
`ifdef MAC_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;
  logic [NUM_REQ-1:0] rot;
  int sum;
  // rotate so bit 0 is the pointer position, then take the lowest set bit
  always_comb begin
    rot = NUM_REQ'({req_valid_in, req_valid_in} >> ptr);
    sum = int'(ptr);
    for (int k = NUM_REQ-1; k >= 0; k--) if (rot[k]) sum = int'(ptr) + k;
    pick = IW'(sum >= NUM_REQ ? sum - NUM_REQ : sum);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (state == OUTPUT && res_ready_out) ptr <= (int'(grant) == NUM_REQ-1) ? '0 : grant + 1'b1;
`else
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) if (req_valid_in[k]) pick = IW'(k);
  end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid_in) state_nxt = BURST;
      BURST:   if (last_pair) state_nxt = WAIT;
      WAIT:    if (mac_valid_in) state_nxt = OUTPUT;
      OUTPUT:  if (res_ready_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    mac_valid_out = (state == BURST) && req_valid_in[grant];
    req_ready_in = (state == BURST) ? ({{(NUM_REQ-1){1'b0}}, mac_ready_out} << grant) : '0;
    mac_ready_in = (state == WAIT);
    mac_dataa_out = req_dataa_in[grant*DATA_WIDTH +: DATA_WIDTH];
    mac_datab_out = req_datab_in[grant*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant <= '0;
      cnt <= '0;
      res_valid_out <= 1'b0;
      res_data_out <= '0;
      res_id_out <= '0;
    end else begin
      if (state == IDLE && |req_valid_in) begin
        grant <= pick;
        cnt <= '0;
      end
      if (pair_hs) cnt <= cnt + 1'b1;
      if (state == WAIT && mac_valid_in) begin
        res_valid_out <= 1'b1;
        res_data_out <= mac_result_in;
        res_id_out <= grant;
      end else if (state == OUTPUT && res_ready_out) res_valid_out <= 1'b0;
    end
endmodule
